hub75_scan_ctrl: RTL and testbench

- Frame scheduler for a 1/8-scan HUB75 RGB panel driven from the Pmod headers.
- Sequences row addressing, per-pixel shift, latch and blanking, and requests bit-plane pixel data from a framebuffer read port.
- Produces binary-code-modulated brightness: each row is shown once per bit-plane, with on-time weighted 2^plane.
- Sits between the framebuffer RAM and the JB/JC pin mapping.

---
 rtl/hub75_scan_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_ctrl.sv
`default_nettype none
// hub75_scan_ctrl: 1/8-scan HUB75 frame scheduler (shift, latch, BCM display, blank), rev 1.0.
// Optional dimming input brightness[7:0] is enabled by defining HUB75_SCAN_DIM_EN.
module hub75_scan_ctrl #(
  parameter int COLS      = 32,
  parameter int ROW_BITS  = 3,
  parameter int BITPLANES = 4,
  parameter int CLK_DIV   = 4,
  parameter int BASE_ON   = 8,
  parameter int LATCH_W   = 1
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  enable,
`ifdef HUB75_SCAN_DIM_EN
  input  logic [7:0]                                            brightness,
`endif
  output logic                                                  fb_rd_en,
  output logic [ROW_BITS+$clog2(COLS)+$clog2(BITPLANES)-1:0]    fb_rd_addr,
  input  logic [5:0]                                            fb_rd_data,
  output logic [5:0]                                            rgb,
  output logic                                                  sclk,
  output logic                                                  latch,
  output logic                                                  oe_n,
  output logic [ROW_BITS-1:0]                                   row_addr,
  output logic                                                  busy,
  output logic                                                  frame_done
);

  localparam int CB      = $clog2(COLS);
  localparam int PB      = $clog2(BITPLANES);
  localparam int PHW     = $clog2(2 * CLK_DIV);
  localparam int ON_MAX  = BASE_ON << (BITPLANES - 1);
  localparam int CNT_MAX = (ON_MAX > LATCH_W) ? ON_MAX : LATCH_W;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [PHW-1:0] PH_LAST    = PHW'(2 * CLK_DIV - 1);
  localparam logic [PHW-1:0] PH_HIGH    = PHW'(CLK_DIV);
  localparam logic [CB-1:0]  COL_LAST   = CB'(COLS - 1);
  localparam logic [PB-1:0]  PLANE_LAST = PB'(BITPLANES - 1);
  localparam logic [CW-1:0]  LATCH_LAST = CW'(LATCH_W - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_LATCH   = 3'd2,
    S_DISPLAY = 3'd3,
    S_DEAD    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PHW-1:0]      ph_q, ph_d;
  logic [CB-1:0]       col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [PB-1:0]       plane_q, plane_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [5:0]          rgb_q, rgb_d;
  logic [ROW_BITS-1:0] row_addr_q, row_addr_d;
`ifdef HUB75_SCAN_DIM_EN
  logic [7:0]          bright_q, bright_d;
`endif

  logic [CW-1:0] win;
  logic          last_plane, last_row, frame_end;

  assign win        = CW'(BASE_ON) << plane_q;
  assign last_plane = (plane_q == PLANE_LAST);
  assign last_row   = &row_q;
  assign frame_end  = (state_q == S_DEAD) && last_plane && last_row;

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    col_d      = col_q;
    row_d      = row_q;
    plane_d    = plane_q;
    cnt_d      = cnt_q;
    rgb_d      = rgb_q;
    row_addr_d = row_addr_q;
`ifdef HUB75_SCAN_DIM_EN
    bright_d   = bright_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_SHIFT;
          row_d   = '0;
          plane_d = '0;
          col_d   = COL_LAST;
          ph_d    = '0;
          cnt_d   = '0;
`ifdef HUB75_SCAN_DIM_EN
          bright_d = brightness;
`endif
        end
      end
      S_SHIFT: begin
        if (ph_q == PHW'(1)) rgb_d = fb_rd_data;
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (col_q == '0) begin
            state_d    = S_LATCH;
            cnt_d      = '0;
            row_addr_d = row_q;
          end else begin
            col_d = col_q - CB'(1);
          end
        end else begin
          ph_d = ph_q + PHW'(1);
        end
      end
      S_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = S_DISPLAY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DISPLAY: begin
        if (cnt_q == win - CW'(1)) begin
          state_d = S_DEAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DEAD: begin
        col_d = COL_LAST;
        ph_d  = '0;
        if (!last_plane) begin
          plane_d = plane_q + PB'(1);
          state_d = S_SHIFT;
        end else begin
          plane_d = '0;
          if (!last_row) begin
            row_d   = row_q + ROW_BITS'(1);
            state_d = S_SHIFT;
          end else begin
            // Frame boundary: the only point where enable is honoured mid-run.
            row_d   = '0;
            state_d = enable ? S_SHIFT : S_IDLE;
`ifdef HUB75_SCAN_DIM_EN
            bright_d = brightness;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      plane_q    <= '0;
      cnt_q      <= '0;
      rgb_q      <= '0;
      row_addr_q <= '0;
`ifdef HUB75_SCAN_DIM_EN
      bright_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      col_q      <= col_d;
      row_q      <= row_d;
      plane_q    <= plane_d;
      cnt_q      <= cnt_d;
      rgb_q      <= rgb_d;
      row_addr_q <= row_addr_d;
`ifdef HUB75_SCAN_DIM_EN
      bright_q   <= bright_d;
`endif
    end
  end

  assign fb_rd_en   = (state_q == S_SHIFT) && (ph_q == '0);
  assign fb_rd_addr = {row_q, col_q, plane_q};
  assign rgb        = rgb_q;
  assign sclk       = (state_q == S_SHIFT) && (ph_q >= PH_HIGH);
  assign latch      = (state_q == S_LATCH);
  assign row_addr   = row_addr_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_end;

`ifdef HUB75_SCAN_DIM_EN
  logic [CW+7:0] on_prod;
  assign on_prod = {8'd0, win} * {{CW{1'b0}}, bright_q};
  // cnt < floor(prod/256) is equivalent to cnt*256 + 255 < prod.
  assign oe_n = !((state_q == S_DISPLAY) && ({cnt_q, 8'hFF} < on_prod));
`else
  assign oe_n = (state_q != S_DISPLAY);
`endif

endmodule
`default_nettype wire

// File: tb/tb_hub75_scan_ctrl.sv
`default_nettype none
// tb_hub75_scan_ctrl: randomized framebuffer contents and enable timing checked against a frame model.
module tb_hub75_scan_ctrl;

  localparam int COLS = 4;
  localparam int RB   = 3;
  localparam int BP   = 2;
  localparam int CD   = 2;
  localparam int BO   = 4;
  localparam int LW   = 1;
  localparam int ROWS = 1 << RB;
  localparam int AW   = RB + 2 + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          fb_rd_en;
  logic [AW-1:0] fb_rd_addr;
  logic [5:0]    fb_rd_data = 6'd0;
  logic [5:0]    rgb;
  logic          sclk, latch, oe_n, busy, frame_done;
  logic [RB-1:0] row_addr;
`ifdef HUB75_SCAN_DIM_EN
  logic [7:0]    brightness = 8'd128;
`endif

  int checks;
  int errors;

  logic [5:0] mem [0:(1<<AW)-1];

  logic [5:0]    got_rgb[$];
  logic [AW-1:0] got_addr[$];
  int            got_run[$];
  logic [RB-1:0] got_lrow[$];
  int            fd_idx[$];

  hub75_scan_ctrl #(
    .COLS(COLS), .ROW_BITS(RB), .BITPLANES(BP), .CLK_DIV(CD), .BASE_ON(BO), .LATCH_W(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
`ifdef HUB75_SCAN_DIM_EN
    .brightness(brightness),
`endif
    .fb_rd_en(fb_rd_en),
    .fb_rd_addr(fb_rd_addr),
    .fb_rd_data(fb_rd_data),
    .rgb(rgb),
    .sclk(sclk),
    .latch(latch),
    .oe_n(oe_n),
    .row_addr(row_addr),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Framebuffer read port: one cycle latency.
  always @(posedge clk) if (fb_rd_en) fb_rd_data <= mem[fb_rd_addr];

  function automatic int on_cycles(input int p);
`ifdef HUB75_SCAN_DIM_EN
    return ((BO << p) * int'(brightness)) >> 8;
`else
    return BO << p;
`endif
  endfunction

  function automatic int frame_len();
    int n = 0;
    for (int p = 0; p < BP; p++) n += COLS * 2 * CD + LW + (BO << p) + 1;
    return n * ROWS;
  endfunction

  function automatic int fb_index(input int r, input int c, input int p);
    return (r * COLS + c) * BP + p;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < (1 << AW); i++) mem[i] = 6'($urandom);
  endtask

  // Samples one whole frame starting at the current negedge (frame cycle 0).
  task automatic collect_frame(input int drop_at);
    int            run;
    logic          psclk, poe;
    logic [RB-1:0] prow;
    got_rgb.delete(); got_addr.delete(); got_run.delete(); got_lrow.delete(); fd_idx.delete();
    run = 0; psclk = 1'b0; poe = 1'b1; prow = row_addr;
    for (int i = 0; i < frame_len(); i++) begin
      if (sclk && !psclk) got_rgb.push_back(rgb);
      if (fb_rd_en) got_addr.push_back(fb_rd_addr);
      if (!oe_n) run++;
      else if (run > 0) begin got_run.push_back(run); run = 0; end
      if (latch) begin
        checks++;
        if (oe_n !== 1'b1) begin errors++; $display("FAIL latch_blank cycle %0d oe_n=%b required 1", i, oe_n); end
        got_lrow.push_back(row_addr);
      end
      if (row_addr !== prow) begin
        checks++;
        if (oe_n !== 1'b1 || poe !== 1'b1) begin
          errors++; $display("FAIL row_change_blank cycle %0d oe_n=%b prev=%b required 1", i, oe_n, poe);
        end
      end
      if (frame_done) fd_idx.push_back(i);
      psclk = sclk; poe = oe_n; prow = row_addr;
      if (i == drop_at) enable = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag);
    int k, j, e;
    checks++;
    if (got_rgb.size() != ROWS * BP * COLS) begin
      errors++; $display("FAIL %s rgb_count got %0d required %0d", tag, got_rgb.size(), ROWS * BP * COLS);
    end
    checks++;
    if (got_addr.size() != ROWS * BP * COLS) begin
      errors++; $display("FAIL %s addr_count got %0d required %0d", tag, got_addr.size(), ROWS * BP * COLS);
    end
    k = 0;
    for (int r = 0; r < ROWS; r++)
      for (int p = 0; p < BP; p++)
        for (int c = COLS - 1; c >= 0; c--) begin
          if (k < got_rgb.size()) begin
            checks++;
            if (got_rgb[k] !== mem[fb_index(r, c, p)]) begin
              errors++; $display("FAIL %s rgb r%0d p%0d c%0d got %h required %h", tag, r, p, c, got_rgb[k], mem[fb_index(r, c, p)]);
            end
          end
          if (k < got_addr.size()) begin
            checks++;
            if (got_addr[k] !== AW'(fb_index(r, c, p))) begin
              errors++; $display("FAIL %s addr r%0d p%0d c%0d got %h required %h", tag, r, p, c, got_addr[k], AW'(fb_index(r, c, p)));
            end
          end
          k++;
        end
    j = 0; e = 0;
    for (int r = 0; r < ROWS; r++)
      for (int p = 0; p < BP; p++) if (on_cycles(p) > 0) e++;
    checks++;
    if (got_run.size() != e) begin
      errors++; $display("FAIL %s on_run_count got %0d required %0d", tag, got_run.size(), e);
    end
    for (int r = 0; r < ROWS; r++)
      for (int p = 0; p < BP; p++)
        if (on_cycles(p) > 0) begin
          if (j < got_run.size()) begin
            checks++;
            if (got_run[j] != on_cycles(p)) begin
              errors++; $display("FAIL %s on_run r%0d p%0d got %0d required %0d", tag, r, p, got_run[j], on_cycles(p));
            end
          end
          j++;
        end
    j = 0;
    checks++;
    if (got_lrow.size() != ROWS * BP * LW) begin
      errors++; $display("FAIL %s latch_count got %0d required %0d", tag, got_lrow.size(), ROWS * BP * LW);
    end
    for (int r = 0; r < ROWS; r++)
      for (int p = 0; p < BP * LW; p++) begin
        if (j < got_lrow.size()) begin
          checks++;
          if (got_lrow[j] !== RB'(r)) begin
            errors++; $display("FAIL %s latch_row got %0d required %0d", tag, got_lrow[j], r);
          end
        end
        j++;
      end
    checks++;
    if (fd_idx.size() != 1) begin
      errors++; $display("FAIL %s frame_done_count got %0d required 1", tag, fd_idx.size());
    end else begin
      checks++;
      if (fd_idx[0] != frame_len() - 1) begin
        errors++; $display("FAIL %s frame_done_cycle got %0d required %0d", tag, fd_idx[0], frame_len() - 1);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({rgb, sclk, latch, oe_n, row_addr, fb_rd_en, busy, frame_done} !== {6'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_outputs got rgb=%h sclk=%b latch=%b oe_n=%b row=%0d rd=%b busy=%b fd=%b required 0,0,0,1,0,0,0,0",
                         rgb, sclk, latch, oe_n, row_addr, fb_rd_en, busy, frame_done);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || oe_n !== 1'b1 || fb_rd_en !== 1'b0) begin
      errors++; $display("FAIL idle_hold got busy=%b oe_n=%b rd=%b required 0,1,0", busy, oe_n, fb_rd_en);
    end
  endtask

  task automatic test_start();
    fill_mem();
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || fb_rd_en !== 1'b1 || fb_rd_addr !== AW'(fb_index(0, COLS - 1, 0))) begin
      errors++; $display("FAIL start got busy=%b rd=%b addr=%h required 1,1,%h", busy, fb_rd_en, fb_rd_addr, AW'(fb_index(0, COLS - 1, 0)));
    end
    for (int i = 0; i < 10 && busy !== 1'b1; i++) @(negedge clk);
    collect_frame(-1);
    check_frame("frame1");
  endtask

  task automatic test_back_to_back();
    int drop;
    checks++;
    if (busy !== 1'b1 || fb_rd_en !== 1'b1 || fb_rd_addr !== AW'(fb_index(0, COLS - 1, 0)) || frame_done !== 1'b0) begin
      errors++; $display("FAIL back_to_back got busy=%b rd=%b addr=%h fd=%b required 1,1,%h,0", busy, fb_rd_en, fb_rd_addr,
                         AW'(fb_index(0, COLS - 1, 0)), frame_done);
    end
    drop = int'($urandom_range(20, frame_len() - 20));
    collect_frame(drop);
    check_frame("frame2_drop");
  endtask

  task automatic test_enable_drop();
    int idle;
    logic [5:0] last;
    last = mem[fb_index(ROWS - 1, 0, BP - 1)];
    checks++;
    if (busy !== 1'b0 || oe_n !== 1'b1 || fb_rd_en !== 1'b0 || sclk !== 1'b0 || latch !== 1'b0 || rgb !== last) begin
      errors++; $display("FAIL stop_idle got busy=%b oe_n=%b rd=%b sclk=%b latch=%b rgb=%h required 0,1,0,0,0,%h",
                         busy, oe_n, fb_rd_en, sclk, latch, rgb, last);
    end
    idle = int'($urandom_range(1, 8));
    repeat (idle) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || oe_n !== 1'b1) begin
      errors++; $display("FAIL stay_idle got busy=%b oe_n=%b required 0,1", busy, oe_n);
    end
    fill_mem();
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || fb_rd_addr !== AW'(fb_index(0, COLS - 1, 0))) begin
      errors++; $display("FAIL restart got busy=%b addr=%h required 1,%h", busy, fb_rd_addr, AW'(fb_index(0, COLS - 1, 0)));
    end
    collect_frame(-1);
    check_frame("frame3_restart");
  endtask

  task automatic test_async_reset();
    bit found = 0;
    for (int i = 0; i < frame_len() && !found; i++) begin
      if (oe_n === 1'b0 && row_addr !== '0) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL display_wait got timeout required display with row>0");
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (oe_n !== 1'b1 || sclk !== 1'b0 || latch !== 1'b0 || row_addr !== '0 || busy !== 1'b0 || rgb !== 6'd0 || fb_rd_en !== 1'b0) begin
      errors++; $display("FAIL async_reset got oe_n=%b sclk=%b latch=%b row=%0d busy=%b rgb=%h rd=%b required 1,0,0,0,0,0,0",
                         oe_n, sclk, latch, row_addr, busy, rgb, fb_rd_en);
    end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || oe_n !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle got busy=%b oe_n=%b required 0,1", busy, oe_n);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    enable = 1'b0;
    fill_mem();
    repeat (3) @(negedge clk);
    test_reset();
    test_start();
    test_back_to_back();
    test_enable_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
